pattern_sweep_checker: RTL and testbench
========================================

PATTERN_SWEEP_CHECKER -- requirements
Module: pattern_sweep_checker

Interface
REQ-001 Parameter N, default 4, number of DUT inputs swept (1..8).
REQ-002 Parameter SETTLE, default 2, extra hold cycles per vector before sampling (>=0).
REQ-003 Parameter TRUTH, default all-zero, width 2**N, expected output; bit v is expected dut_f for stim==v.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 start  input  1  run request; sampled only in IDLE.
REQ-007 dut_f  input  1  DUT output under test.
REQ-008 stim  output  N  vector driven to DUT inputs, MSB = first DUT input.
REQ-009 busy  output  1  high while a sweep is in progress.
REQ-010 done  output  1  one-cycle pulse at sweep completion.
REQ-011 pass  output  1  high when last completed sweep had zero mismatches.
REQ-012 err_count  output  N+1  mismatches in current/last sweep.
REQ-013 first_err  output  N  vector of first mismatch.
REQ-014 first_err_valid  output  1  first_err holds a captured vector.

Function
REQ-015 FSM states IDLE, APPLY, DONE; IDLE->APPLY on start, APPLY->DONE after vector 2**N-1 sampled, DONE->IDLE unconditionally next cycle.
REQ-016 Edge accepting start clears err_count, pass, first_err, first_err_valid and loads stim=0.
REQ-017 Each vector v held on stim for exactly SETTLE+1 cycles; dut_f sampled on the last cycle of that window.
REQ-018 stim increments by 1 after each sample; no wrap-around occurs, since the sweep ends at 2**N-1.
REQ-019 Sample with dut_f != TRUTH[v] increments err_count by 1; no saturation needed (max 2**N fits N+1 bits).
REQ-020 First mismatch of a sweep loads first_err=v and sets first_err_valid; later mismatches leave both unchanged.
REQ-021 busy high in APPLY only; done high in DONE only.
REQ-022 pass updated in DONE cycle to (err_count==0), including the final sample's result.
REQ-023 Latency: start accepted at edge k -> done high in the cycle following edge k+1+2**N*(SETTLE+1).
REQ-024 start while APPLY or DONE is ignored, with no restart or queueing.
REQ-025 err_count, pass, first_err, first_err_valid, stim hold their values in IDLE until next accepted start.
REQ-026 dut_f is treated as combinational in stim; no handshake with the DUT.

Reset
REQ-027 rst high at a clock edge forces IDLE; stim=0, busy=0, done=0, pass=0, err_count=0, first_err=0, first_err_valid=0.
REQ-028 rst mid-sweep aborts with no done pulse; rst has priority over start on the same edge.

Structure
REQ-029 Shared package pattern_sweep_pkg holds the FSM state typedef and the default SETTLE constant.
REQ-030 Per-vector hold counter is one sub-module, settle_cnt (load SETTLE, decrement, terminal flag).

Verification
REQ-031 N=4, SETTLE=2, TRUTH=16'h6996, DUT model = 4-input XOR -> done 49 cycles after start edge, pass=1, err_count=0, first_err_valid=0.
REQ-032 Same TRUTH, DUT = XNOR -> err_count=16, first_err=0, first_err_valid=1, pass=0.
REQ-033 DUT = XOR except output flipped at input 4'b1010 -> err_count=1, first_err=10, pass=0.
REQ-034 rst asserted 20 cycles into sweep -> all outputs 0 next cycle, no done; new start completes with pass=1.
REQ-035 start held high for entire sweep -> exactly one done pulse at cycle 49, then a second sweep starts from IDLE.
REQ-036 N=2, SETTLE=0, TRUTH=4'b1000, DUT = AND -> stim sequence 0,1,2,3 one cycle each, done 5 cycles after start edge, pass=1.

Source files
------------

// File: rtl/pattern_sweep_pkg.sv
// Shared types and constants for the exhaustive input-pattern sweep checker.
package pattern_sweep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int DEFAULT_SETTLE = 2;

    // Bits needed to hold 0..max_val; never less than one bit.
    function automatic int cnt_width(input int max_val);
        if (max_val > 0) begin
            return $clog2(max_val + 1);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/pattern_sweep_checker_settle_cnt.sv
// Per-vector hold counter: loads the settle length, counts down, flags zero.
module settle_cnt
    import pattern_sweep_pkg::*;
#(
    parameter int LOAD_VAL = DEFAULT_SETTLE
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_load,
    input  logic i_dec,
    output logic o_tc
);

    localparam int CW = cnt_width(LOAD_VAL);

    logic [CW-1:0] r_cnt;

    // Down-counter that parks at zero until reloaded.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= {CW{1'b0}};
        end else if (i_load) begin
            r_cnt <= CW'(LOAD_VAL);
        end else if (i_dec && (r_cnt != {CW{1'b0}})) begin
            r_cnt <= r_cnt - {{(CW-1){1'b0}}, 1'b1};
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_tc = (r_cnt == {CW{1'b0}});

endmodule

// File: rtl/pattern_sweep_checker.sv
// Drives every N-bit vector to a DUT, compares its output against a truth
// table and reports mismatch count, first failing vector and pass/fail.
module pattern_sweep_checker
    import pattern_sweep_pkg::*;
#(
    parameter int               N      = 4,
    parameter int               SETTLE = DEFAULT_SETTLE,
    parameter logic [2**N-1:0]  TRUTH  = {(2**N){1'b0}}
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic         i_dut_f,
    output logic [N-1:0] o_stim,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_pass,
    output logic [N:0]   o_err_count,
    output logic [N-1:0] o_first_err,
    output logic         o_first_err_valid
);

    localparam logic [N-1:0] LAST_VEC = {N{1'b1}};

    state_t       r_state;
    state_t       w_state_nxt;
    logic [N-1:0] r_stim;
    logic         r_busy;
    logic         r_done;
    logic         r_pass;
    logic [N:0]   r_err_count;
    logic [N-1:0] r_first_err;
    logic         r_first_err_valid;

    // One-deep sample stage: compare result is accumulated the cycle after
    // sampling, which is where the extra cycle of start-to-done latency lives.
    logic         r_smp_valid;
    logic         r_smp_mis;
    logic [N-1:0] r_smp_vec;
    logic         r_smp_last;

    logic         w_accept;
    logic         w_tc;
    logic         w_drain;
    logic         w_sample_en;
    logic         w_cnt_load;
    logic         w_cnt_dec;
    logic [N:0]   w_err_nxt;
    logic         w_busy_nxt;
    logic         w_done_nxt;

    assign w_accept    = (r_state == ST_IDLE) && i_start;
    assign w_drain     = r_smp_valid && r_smp_last;
    assign w_sample_en = (r_state == ST_APPLY) && w_tc && !w_drain;
    assign w_cnt_load  = w_accept || w_sample_en;
    assign w_cnt_dec   = (r_state == ST_APPLY) && !w_tc;

    settle_cnt #(
        .LOAD_VAL (SETTLE)
    ) u_settle_cnt (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_load (w_cnt_load),
        .i_dec  (w_cnt_dec),
        .o_tc   (w_tc)
    );

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_nxt = ST_APPLY;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_APPLY: begin
                if (w_drain) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_APPLY;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM output decode, taken from the next state so the flags are registered.
    always_comb begin
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b0;
        case (w_state_nxt)
            ST_APPLY: begin
                w_busy_nxt = 1'b1;
            end
            ST_DONE: begin
                w_done_nxt = 1'b1;
            end
            default: begin
                w_busy_nxt = 1'b0;
                w_done_nxt = 1'b0;
            end
        endcase
    end

    // Mismatch count including the sample currently being retired.
    always_comb begin
        w_err_nxt = r_err_count;
        if (r_smp_valid && r_smp_mis) begin
            w_err_nxt = r_err_count + {{N{1'b0}}, 1'b1};
        end else begin
            w_err_nxt = r_err_count;
        end
    end

    // Status flag registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
        end
    end

    // Stimulus, sample stage and result datapath.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_stim            <= {N{1'b0}};
            r_pass            <= 1'b0;
            r_err_count       <= {(N+1){1'b0}};
            r_first_err       <= {N{1'b0}};
            r_first_err_valid <= 1'b0;
            r_smp_valid       <= 1'b0;
            r_smp_mis         <= 1'b0;
            r_smp_vec         <= {N{1'b0}};
            r_smp_last        <= 1'b0;
        end else if (w_accept) begin
            r_stim            <= {N{1'b0}};
            r_pass            <= 1'b0;
            r_err_count       <= {(N+1){1'b0}};
            r_first_err       <= {N{1'b0}};
            r_first_err_valid <= 1'b0;
            r_smp_valid       <= 1'b0;
            r_smp_mis         <= 1'b0;
            r_smp_vec         <= {N{1'b0}};
            r_smp_last        <= 1'b0;
        end else begin
            r_smp_valid <= w_sample_en;
            if (w_sample_en) begin
                r_smp_mis  <= (i_dut_f != TRUTH[r_stim]);
                r_smp_vec  <= r_stim;
                r_smp_last <= (r_stim == LAST_VEC);
                if (r_stim != LAST_VEC) begin
                    r_stim <= r_stim + {{(N-1){1'b0}}, 1'b1};
                end
            end
            r_err_count <= w_err_nxt;
            if (r_smp_valid && r_smp_mis && !r_first_err_valid) begin
                r_first_err       <= r_smp_vec;
                r_first_err_valid <= 1'b1;
            end
            if ((r_state == ST_APPLY) && (w_state_nxt == ST_DONE)) begin
                r_pass <= (w_err_nxt == {(N+1){1'b0}});
            end
        end
    end

    assign o_stim            = r_stim;
    assign o_busy            = r_busy;
    assign o_done            = r_done;
    assign o_pass            = r_pass;
    assign o_err_count       = r_err_count;
    assign o_first_err       = r_first_err;
    assign o_first_err_valid = r_first_err_valid;

endmodule

// File: tb/tb_pattern_sweep_checker.sv
// Directed bench: a 4-input XOR-family DUT model on one checker and a
// 2-input AND on a second, faster-sweeping checker.
module tb_pattern_sweep_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start_a = 1'b0;
    logic       start_b = 1'b0;
    logic [1:0] mode = 2'd0;

    logic       dut_f_a, dut_f_b;
    logic [3:0] stim_a, fe_a;
    logic [4:0] err_a;
    logic       busy_a, done_a, pass_a, fev_a;
    logic [1:0] stim_b, fe_b;
    logic [2:0] err_b;
    logic       busy_b, done_b, pass_b, fev_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // mode 0: XOR, mode 1: XNOR, mode 2: XOR with output flipped at 4'b1010
    assign dut_f_a = (^stim_a) ^ (mode == 2'd1) ^ ((mode == 2'd2) && (stim_a == 4'd10));
    assign dut_f_b = &stim_b;

    pattern_sweep_checker #(.N(4), .SETTLE(2), .TRUTH(16'h6996)) u_dut_a (
        .i_clk(clk), .i_rst(rst), .i_start(start_a), .i_dut_f(dut_f_a),
        .o_stim(stim_a), .o_busy(busy_a), .o_done(done_a), .o_pass(pass_a),
        .o_err_count(err_a), .o_first_err(fe_a), .o_first_err_valid(fev_a)
    );

    pattern_sweep_checker #(.N(2), .SETTLE(0), .TRUTH(4'b1000)) u_dut_b (
        .i_clk(clk), .i_rst(rst), .i_start(start_b), .i_dut_f(dut_f_b),
        .o_stim(stim_b), .o_busy(busy_b), .o_done(done_b), .o_pass(pass_b),
        .o_err_count(err_b), .o_first_err(fe_b), .o_first_err_valid(fev_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start_a();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
    endtask

    task automatic wait_done_a(output int cyc);
        cyc = 0;
        while ((done_a !== 1'b1) && (cyc < 300)) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total++;
        if ({stim_a, busy_a, done_a, pass_a, err_a, fe_a, fev_a} !== 17'd0) begin
            bad++;
            $display("FAIL reset_a: got %h want 0", {stim_a, busy_a, done_a, pass_a, err_a, fe_a, fev_a});
        end
        total++;
        if ({stim_b, busy_b, done_b, pass_b, err_b, fe_b, fev_b} !== 11'd0) begin
            bad++;
            $display("FAIL reset_b: got %h want 0", {stim_b, busy_b, done_b, pass_b, err_b, fe_b, fev_b});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_xor_pass();
        int cyc;
        mode = 2'd0;
        pulse_start_a();
        total++;
        if (busy_a !== 1'b1) begin bad++; $display("FAIL xor_busy: got %b want 1", busy_a); end
        wait_done_a(cyc);
        cyc = cyc;
        total++;
        if (cyc !== 49) begin bad++; $display("FAIL xor_latency: got %0d want 49", cyc); end
        total++;
        if ({pass_a, err_a, fev_a, busy_a} !== {1'b1, 5'd0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL xor_result: pass=%b err=%0d fev=%b busy=%b want 1 0 0 0", pass_a, err_a, fev_a, busy_a);
        end
        tick();
        total++;
        if (done_a !== 1'b0) begin bad++; $display("FAIL xor_done_pulse: got %b want 0", done_a); end
        repeat (10) tick();
        total++;
        if ({pass_a, err_a, stim_a, busy_a} !== {1'b1, 5'd0, 4'd15, 1'b0}) begin
            bad++;
            $display("FAIL idle_hold: pass=%b err=%0d stim=%0d busy=%b want 1 0 15 0", pass_a, err_a, stim_a, busy_a);
        end
    endtask

    task automatic test_xnor_all_fail();
        int cyc;
        mode = 2'd1;
        pulse_start_a();
        wait_done_a(cyc);
        total++;
        if (cyc !== 49) begin bad++; $display("FAIL xnor_latency: got %0d want 49", cyc); end
        total++;
        if ({err_a, fe_a, fev_a, pass_a} !== {5'd16, 4'd0, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL xnor_result: err=%0d fe=%0d fev=%b pass=%b want 16 0 1 0", err_a, fe_a, fev_a, pass_a);
        end
        tick();
    endtask

    task automatic test_single_flip();
        int cyc;
        mode = 2'd2;
        pulse_start_a();
        total++;
        if ({pass_a, err_a, fev_a} !== 7'd0) begin
            bad++;
            $display("FAIL flip_clear: pass=%b err=%0d fev=%b want 0 0 0", pass_a, err_a, fev_a);
        end
        wait_done_a(cyc);
        total++;
        if ({err_a, fe_a, fev_a, pass_a} !== {5'd1, 4'd10, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL flip_result: err=%0d fe=%0d fev=%b pass=%b want 1 10 1 0", err_a, fe_a, fev_a, pass_a);
        end
        tick();
    endtask

    task automatic test_reset_mid_sweep();
        int cyc;
        int n_done;
        mode = 2'd1;
        pulse_start_a();
        repeat (19) tick();
        total++;
        if ({err_a, fev_a, busy_a} !== {5'd6, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL mid_progress: err=%0d fev=%b busy=%b want 6 1 1", err_a, fev_a, busy_a);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mode = 2'd0;
        total++;
        if ({stim_a, busy_a, done_a, pass_a, err_a, fe_a, fev_a} !== 17'd0) begin
            bad++;
            $display("FAIL mid_reset: got %h want 0", {stim_a, busy_a, done_a, pass_a, err_a, fe_a, fev_a});
        end
        n_done = 0;
        for (int c = 0; c < 60; c++) begin
            tick();
            if (done_a === 1'b1) n_done++;
        end
        total++;
        if (n_done !== 0) begin bad++; $display("FAIL mid_no_done: got %0d pulses want 0", n_done); end
        rst = 1'b1;
        start_a = 1'b1;
        tick();
        rst = 1'b0;
        start_a = 1'b0;
        total++;
        if (busy_a !== 1'b0) begin bad++; $display("FAIL rst_priority: busy=%b want 0", busy_a); end
        pulse_start_a();
        wait_done_a(cyc);
        total++;
        if ({cyc == 49, pass_a, err_a} !== {1'b1, 1'b1, 5'd0}) begin
            bad++;
            $display("FAIL restart: cyc=%0d pass=%b err=%0d want 49 1 0", cyc, pass_a, err_a);
        end
        tick();
    endtask

    task automatic test_start_held();
        int cyc;
        int n_done;
        int first_done;
        mode = 2'd0;
        start_a = 1'b1;
        tick();
        n_done = 0;
        first_done = -1;
        for (int c = 1; c <= 51; c++) begin
            tick();
            if (done_a === 1'b1) begin
                n_done++;
                if (first_done < 0) first_done = c;
            end
        end
        total++;
        if ({n_done, first_done} !== {32'sd1, 32'sd49}) begin
            bad++;
            $display("FAIL held_one_done: count=%0d first=%0d want 1 49", n_done, first_done);
        end
        total++;
        if ({busy_a, pass_a} !== 2'b10) begin
            bad++;
            $display("FAIL held_second_sweep: busy=%b pass=%b want 1 0", busy_a, pass_a);
        end
        start_a = 1'b0;
        wait_done_a(cyc);
        total++;
        if ({cyc == 49, pass_a} !== 2'b11) begin
            bad++;
            $display("FAIL held_second_done: cyc=%0d pass=%b want 49 1", cyc, pass_a);
        end
        tick();
    endtask

    task automatic test_small_and();
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        total++;
        if ({stim_b, busy_b} !== {2'd0, 1'b1}) begin
            bad++;
            $display("FAIL and_first: stim=%0d busy=%b want 0 1", stim_b, busy_b);
        end
        for (int j = 1; j <= 3; j++) begin
            tick();
            total++;
            if (stim_b !== j[1:0]) begin bad++; $display("FAIL and_stim: got %0d want %0d", stim_b, j); end
        end
        tick();
        total++;
        if ({done_b, stim_b} !== {1'b0, 2'd3}) begin
            bad++;
            $display("FAIL and_drain: done=%b stim=%0d want 0 3", done_b, stim_b);
        end
        tick();
        total++;
        if ({done_b, pass_b, err_b, fev_b, busy_b} !== {1'b1, 1'b1, 3'd0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL and_done: done=%b pass=%b err=%0d fev=%b busy=%b want 1 1 0 0 0",
                     done_b, pass_b, err_b, fev_b, busy_b);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_xor_pass();
        test_xnor_all_fail();
        test_single_flip();
        test_reset_mid_sweep();
        test_start_held();
        test_small_and();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
